// File: rtl/ring_output_ctrl_pkg.sv
// Shared definitions for the ring router output controller:
// packet field positions, virtual-channel encodings and phase helpers.
package ring_output_ctrl_pkg;

  localparam int RING_DATA_W = 64;
  localparam int RING_VC_BIT = 63;
  localparam int RING_DIR_BIT = 62;
  localparam int RING_HOP_HI = 61;
  localparam int RING_HOP_LO = 56;
  localparam int RING_CNT_W = 16;

  typedef enum logic {
    VC_EVEN = 1'b0,
    VC_ODD  = 1'b1
  } vc_e;

  // The VC that owns the router internals (may be written) in a given phase.
  function automatic vc_e written_vc(input logic polarity);
    return polarity ? VC_ODD : VC_EVEN;
  endfunction

  // The link always serves the VC opposite to the one being written.
  function automatic vc_e served_vc(input logic polarity);
    return polarity ? VC_EVEN : VC_ODD;
  endfunction

endpackage

// File: rtl/ring_output_ctrl_if.sv
// Arbitrator-side write strobes, empty feedback and outbound link of one
// ring output controller, bundled as a single interface.
interface ring_output_ctrl_if #(
  parameter int DATA_W = ring_output_ctrl_pkg::RING_DATA_W,
  parameter int CNT_W  = ring_output_ctrl_pkg::RING_CNT_W
);

  logic              polarity;
  logic [DATA_W-1:0] even_out_data;
  logic              even_out_enable;
  logic [DATA_W-1:0] odd_out_data;
  logic              odd_out_enable;
  logic              even_out_empty;
  logic              odd_out_empty;
  logic              send_out;
  logic [DATA_W-1:0] data_out;
  logic              ready_in;
  logic [CNT_W-1:0]  sent_count;
  logic              protocol_err;

  modport master (
    output polarity,
    output even_out_data,
    output even_out_enable,
    output odd_out_data,
    output odd_out_enable,
    output ready_in,
    input  even_out_empty,
    input  odd_out_empty,
    input  send_out,
    input  data_out,
    input  sent_count,
    input  protocol_err
  );

  modport slave (
    input  polarity,
    input  even_out_data,
    input  even_out_enable,
    input  odd_out_data,
    input  odd_out_enable,
    input  ready_in,
    output even_out_empty,
    output odd_out_empty,
    output send_out,
    output data_out,
    output sent_count,
    output protocol_err
  );

endinterface

// File: rtl/ring_output_ctrl_vc_slot.sv
// One-deep packet buffer for a single virtual channel: holds the data,
// the full flag, a registered empty flag and the write-legality check.
module vc_slot
  import ring_output_ctrl_pkg::*;
#(
  parameter int  DATA_W = RING_DATA_W,
  parameter int  VC_BIT = RING_VC_BIT,
  parameter vc_e VC_ID  = VC_EVEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_phase_ok,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_clear,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_data,
  output logic              o_err
);

  logic              r_full;
  logic              r_empty;
  logic [DATA_W-1:0] r_data;

  logic w_accept;
  logic w_vc_mismatch;
  logic w_full_next;

  // Clear and accept are mutually exclusive: clear needs a full slot, accept an empty one.
  always_comb begin
    w_accept      = i_wr_en && i_phase_ok && !r_full;
    w_vc_mismatch = i_wr_data[VC_BIT] != VC_ID;
    w_full_next   = r_full;
    if (i_clear) begin
      w_full_next = 1'b0;
    end else if (w_accept) begin
      w_full_next = 1'b1;
    end
  end

  // A mismatched VC bit still stores the packet; only the flag is raised.
  assign o_err = i_wr_en && (!w_accept || w_vc_mismatch);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_data  <= '0;
    end else begin
      r_full  <= w_full_next;
      r_empty <= !w_full_next;
      if (w_accept) begin
        r_data <= i_wr_data;
      end
    end
  end

  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_data  = r_data;

endmodule

// File: rtl/ring_output_ctrl.sv
// Per-direction output controller of a ring router: two VC slots drained
// onto one link, time-multiplexed by the global polarity.
module ring_output_ctrl
  import ring_output_ctrl_pkg::*;
#(
  parameter int DATA_W = RING_DATA_W,
  parameter int VC_BIT = RING_VC_BIT,
  parameter int CNT_W  = RING_CNT_W
) (
  input logic               clk,
  input logic               reset,
  ring_output_ctrl_if.slave bus
);

  logic              r_send;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_count;
  logic              r_err;

  vc_e               w_served_vc;
  logic              w_served_full;
  logic [DATA_W-1:0] w_served_data;
  logic              w_send;
  logic              w_even_phase_ok;
  logic              w_odd_phase_ok;
  logic              w_clear_even;
  logic              w_clear_odd;
  logic              w_even_full;
  logic              w_odd_full;
  logic              w_even_empty;
  logic              w_odd_empty;
  logic [DATA_W-1:0] w_even_data;
  logic [DATA_W-1:0] w_odd_data;
  logic              w_even_err;
  logic              w_odd_err;

  assign w_even_phase_ok = written_vc(bus.polarity) == VC_EVEN;
  assign w_odd_phase_ok  = written_vc(bus.polarity) == VC_ODD;
  assign w_served_vc     = served_vc(bus.polarity);

  always_comb begin
    w_served_full = w_odd_full;
    w_served_data = w_odd_data;
    if (w_served_vc == VC_EVEN) begin
      w_served_full = w_even_full;
      w_served_data = w_even_data;
    end
  end

  assign w_send       = w_served_full && bus.ready_in;
  assign w_clear_even = w_send && (w_served_vc == VC_EVEN);
  assign w_clear_odd  = w_send && (w_served_vc == VC_ODD);

  vc_slot #(
    .DATA_W (DATA_W),
    .VC_BIT (VC_BIT),
    .VC_ID  (VC_EVEN)
  ) u_even_slot (
    .clk        (clk),
    .reset      (reset),
    .i_phase_ok (w_even_phase_ok),
    .i_wr_en    (bus.even_out_enable),
    .i_wr_data  (bus.even_out_data),
    .i_clear    (w_clear_even),
    .o_full     (w_even_full),
    .o_empty    (w_even_empty),
    .o_data     (w_even_data),
    .o_err      (w_even_err)
  );

  vc_slot #(
    .DATA_W (DATA_W),
    .VC_BIT (VC_BIT),
    .VC_ID  (VC_ODD)
  ) u_odd_slot (
    .clk        (clk),
    .reset      (reset),
    .i_phase_ok (w_odd_phase_ok),
    .i_wr_en    (bus.odd_out_enable),
    .i_wr_data  (bus.odd_out_data),
    .i_clear    (w_clear_odd),
    .o_full     (w_odd_full),
    .o_empty    (w_odd_empty),
    .o_data     (w_odd_data),
    .o_err      (w_odd_err)
  );

  // data_out holds the last packet between sends; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_send  <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_send <= w_send;
      if (w_send) begin
        r_data <= w_served_data;
        if (!(&r_count)) begin
          r_count <= r_count + CNT_W'(1);
        end
      end
      if (w_even_err || w_odd_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.even_out_empty = w_even_empty;
  assign bus.odd_out_empty  = w_odd_empty;
  assign bus.send_out       = r_send;
  assign bus.data_out       = r_data;
  assign bus.sent_count     = r_count;
  assign bus.protocol_err   = r_err;

endmodule
